// File: rtl/id_issue_sb_pkg.sv
// Shared defaults for the decode issue scoreboard.
// Define ID_PERF_CNT_EN to build the hazard stall counter in id_issue_sb.
`ifndef FS_TO_DS_BUS_WD
`define FS_TO_DS_BUS_WD 64
`endif

package id_issue_sb_pkg;
    localparam int DEF_NREG     = 32;
    localparam int DEF_AW       = 5;
    localparam int DEF_MAX_INFL = 3;
    localparam int FS_TO_DS_W   = `FS_TO_DS_BUS_WD;
`ifdef ID_PERF_CNT_EN
    localparam bit PERF_CNT_EN  = 1'b1;
`else
    localparam bit PERF_CNT_EN  = 1'b0;
`endif
endpackage

// File: rtl/id_issue_sb_sb_entry.sv
// Per-register in-flight writer counter: saturates at MAX_INFL, holds at 0.
// A simultaneous inc and dec leaves the count unchanged.
module sb_entry #(
    parameter int MAX_INFL = 3,
    parameter int CW       = $clog2(MAX_INFL + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          busy,
    output logic          full
);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFL);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0);
    assign full = (cnt_q == CNT_MAX);

`ifndef SYNTHESIS
    // Retiring a register with nothing in flight means WB and the scoreboard disagree.
    retire_underflow: assert property (@(posedge clk) disable iff (!resetn)
        !(dec && !inc && cnt_q == '0));
`endif
endmodule

// File: rtl/id_issue_sb.sv
// Decode issue controller: holds one instruction, issues 1 cycle after capture unless a RAW or
// in-flight-limit hazard stalls it (in_ready drops while stalled). ID_PERF_CNT_EN builds stall_cnt.
module id_issue_sb
    import id_issue_sb_pkg::*;
#(
    parameter int NREG      = DEF_NREG,
    parameter int AW        = DEF_AW,
    parameter int MAX_INFL  = DEF_MAX_INFL,
    parameter int CW        = $clog2(MAX_INFL + 1),
    parameter int PAYLOAD_W = FS_TO_DS_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic                 in_src1_en,
    input  logic                 in_src2_en,
    input  logic [AW-1:0]        in_src1,
    input  logic [AW-1:0]        in_src2,
    input  logic                 in_dst_we,
    input  logic [AW-1:0]        in_dst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_dst_we,
    output logic [AW-1:0]        out_dst,
    input  logic                 flush,
    input  logic                 ret_valid,
    input  logic [AW-1:0]        ret_dst,
    output logic [31:0]          stall_cnt
);
    localparam int NSLOT = 1 << AW;

    logic                 hold_vld_q, hold_vld_d;
    logic [PAYLOAD_W-1:0] dat_q;
    logic                 src1_en_q, src2_en_q, dst_we_q;
    logic [AW-1:0]        src1_q, src2_q, dst_q;

    logic [NSLOT-1:0]     busy, full;
    logic [CW-1:0]        cnt [NSLOT];
    logic                 hazard, issue, load;

    // Slots for r0 and for addresses beyond NREG never report busy/full.
    for (genvar g = 0; g < NSLOT; g++) begin : g_sb
        if (g > 0 && g < NREG) begin : g_ent
            sb_entry #(.MAX_INFL(MAX_INFL), .CW(CW)) u_ent (
                .clk   (clk),
                .resetn(resetn),
                .inc   (issue && dst_we_q && dst_q == AW'(g)),
                .dec   (ret_valid && ret_dst == AW'(g)),
                .cnt   (cnt[g]),
                .busy  (busy[g]),
                .full  (full[g])
            );
        end else begin : g_none
            assign cnt[g]  = '0;
            assign busy[g] = 1'b0;
            assign full[g] = 1'b0;
        end
`ifndef SYNTHESIS
        cnt_bound: assert property (@(posedge clk) disable iff (!resetn)
            cnt[g] <= CW'(MAX_INFL));
`endif
    end

    // Counts are read before this cycle's issue/retire update.
    assign hazard = (src1_en_q && src1_q != '0 && busy[src1_q])
                 || (src2_en_q && src2_q != '0 && busy[src2_q])
                 || (dst_we_q && full[dst_q]);

    assign out_valid  = hold_vld_q && !hazard && !flush;
    assign issue      = out_valid && out_ready;
    assign in_ready   = !hold_vld_q || issue;
    assign load       = in_valid && in_ready && !flush;
    assign out_data   = dat_q;
    assign out_dst    = dst_q;
    assign out_dst_we = dst_we_q;

    always_comb begin
        hold_vld_d = hold_vld_q;
        if (flush) begin
            hold_vld_d = 1'b0;
        end else if (load) begin
            hold_vld_d = 1'b1;
        end else if (issue) begin
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_vld_q <= 1'b0;
            dat_q      <= '0;
            src1_en_q  <= 1'b0;
            src2_en_q  <= 1'b0;
            src1_q     <= '0;
            src2_q     <= '0;
            dst_we_q   <= 1'b0;
            dst_q      <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            if (load) begin
                dat_q     <= in_data;
                src1_en_q <= in_src1_en;
                src2_en_q <= in_src2_en;
                src1_q    <= in_src1;
                src2_q    <= in_src2;
                // r0 writes are architecturally void, so never tracked or exported.
                dst_we_q  <= in_dst_we && in_dst != '0;
                dst_q     <= in_dst;
            end
        end
    end

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
        end else if (hold_vld_q && hazard && !flush && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_id_issue_sb.sv
// Bench for id_issue_sb: directed table, hand-written corner sequences, randomized run vs queue model.
module tb_id_issue_sb;
    localparam int NREG = 32, AW = 5, MAX_INFL = 3, CW = 2, PW = 64;
`ifdef ID_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn = 1'b1;
    logic          in_valid = 0, in_ready;
    logic [PW-1:0] in_data = '0;
    logic          in_src1_en = 0, in_src2_en = 0;
    logic [AW-1:0] in_src1 = '0, in_src2 = '0;
    logic          in_dst_we = 0;
    logic [AW-1:0] in_dst = '0;
    logic          out_valid, out_ready = 0;
    logic [PW-1:0] out_data;
    logic          out_dst_we;
    logic [AW-1:0] out_dst;
    logic          flush = 0, ret_valid = 0;
    logic [AW-1:0] ret_dst = '0;
    logic [31:0]   stall_cnt;

    id_issue_sb #(.NREG(NREG), .AW(AW), .MAX_INFL(MAX_INFL), .CW(CW), .PAYLOAD_W(PW)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_src1_en(in_src1_en), .in_src2_en(in_src2_en), .in_src1(in_src1), .in_src2(in_src2),
        .in_dst_we(in_dst_we), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dst_we(out_dst_we), .out_dst(out_dst),
        .flush(flush), .ret_valid(ret_valid), .ret_dst(ret_dst), .stall_cnt(stall_cnt)
    );

    typedef struct {
        bit v; logic [63:0] d; bit s1e; int s1; bit s2e; int s2; bit we; int dst;
    } ins_t;
    typedef struct {
        ins_t ii; bit ordy; bit fl; bit rv; int rd; bit e_ov; bit e_irdy; bit e_we;
    } vec_t;

    int errors = 0, checks = 0;

    // Reference state: held instruction plus a list of issued-but-not-retired destinations.
    bit          m_vld;
    logic [63:0] m_dat;
    bit          m_s1e, m_s2e, m_we;
    int          m_s1, m_s2, m_dst;
    int          pend[$];
    longint      m_stall;
    bit          s_ov, s_irdy, s_we;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int inflight(input int r);
        int n = 0;
        foreach (pend[i]) if (pend[i] == r) n++;
        return n;
    endfunction

    function automatic ins_t mk(input bit v, input logic [63:0] d, input bit s1e, input int s1,
                                input bit s2e, input int s2, input bit we, input int dst);
        ins_t t;
        t.v = v; t.d = d; t.s1e = s1e; t.s1 = s1; t.s2e = s2e; t.s2 = s2; t.we = we; t.dst = dst;
        return t;
    endfunction

    // Called at a negedge; drives, checks combinational outputs, advances one cycle.
    task automatic step(input ins_t ii, input bit ordy, input bit fl, input bit rv, input int rd);
        bit haz, e_ov, e_iss, e_irdy;
        in_valid = ii.v; in_data = ii.d;
        in_src1_en = ii.s1e; in_src1 = AW'(ii.s1);
        in_src2_en = ii.s2e; in_src2 = AW'(ii.s2);
        in_dst_we = ii.we; in_dst = AW'(ii.dst);
        out_ready = ordy; flush = fl; ret_valid = rv; ret_dst = AW'(rd);
        #1;
        haz = m_vld && ((m_s1e && m_s1 != 0 && inflight(m_s1) != 0)
                     || (m_s2e && m_s2 != 0 && inflight(m_s2) != 0)
                     || (m_we && m_dst != 0 && inflight(m_dst) >= MAX_INFL));
        e_ov   = m_vld && !haz && !fl;
        e_iss  = e_ov && ordy;
        e_irdy = !m_vld || e_iss;
        s_ov = out_valid; s_irdy = in_ready; s_we = out_dst_we;
        chk("out_valid", out_valid, e_ov);
        chk("in_ready", in_ready, e_irdy);
        chk("stall_cnt", stall_cnt, PERF ? m_stall : 64'd0);
        if (m_vld) begin
            chk("out_data", out_data, m_dat);
            chk("out_dst", out_dst, m_dst);
            chk("out_dst_we", out_dst_we, m_we && m_dst != 0);
        end
        @(posedge clk);
        if (m_vld && haz && !fl) m_stall++;
        if (e_iss && m_we && m_dst != 0) pend.push_back(m_dst);
        if (rv && rd != 0) begin
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i] == rd) begin
                    pend.delete(i);
                    break;
                end
            end
        end
        if (fl) m_vld = 0;
        else if (ii.v && e_irdy) begin
            m_vld = 1; m_dat = ii.d; m_s1e = ii.s1e; m_s1 = ii.s1; m_s2e = ii.s2e; m_s2 = ii.s2;
            m_we = ii.we; m_dst = ii.dst;
        end else if (e_iss) m_vld = 0;
        @(negedge clk);
    endtask

    task automatic chk_all_cnt(input string nm);
        for (int r = 0; r < NREG; r++) chk($sformatf("%s_cnt%0d", nm, r), dut.cnt[r], inflight(r));
    endtask

    task automatic do_reset();
        in_valid = 0; in_src1_en = 0; in_src2_en = 0; in_dst_we = 0;
        out_ready = 0; flush = 0; ret_valid = 0;
        resetn = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_out_dst_we", out_dst_we, 0);
        m_vld = 0; pend.delete(); m_stall = 0;
        repeat (2) @(negedge clk);
        chk_all_cnt("rst");
        resetn = 1;
    endtask

    vec_t tbl[10];
    ins_t nop;

    initial begin
        nop = mk(0, 64'h0, 0, 0, 0, 0, 0, 0);
        // RAW on r5 (3 stall cycles), then r0 writer and r0 reader.
        tbl[0] = '{mk(1, 64'hA0, 0, 0, 0, 0, 1, 5), 1, 0, 0, 0, 0, 1, 0};
        tbl[1] = '{mk(1, 64'hB1, 1, 5, 0, 0, 0, 0), 1, 0, 0, 0, 1, 1, 1};
        tbl[2] = '{nop, 1, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{nop, 1, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{nop, 1, 0, 1, 5, 0, 0, 0};
        tbl[5] = '{nop, 1, 0, 0, 0, 1, 1, 0};
        tbl[6] = '{mk(1, 64'hC2, 0, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0, 1, 0};
        tbl[7] = '{mk(1, 64'hD3, 1, 0, 1, 0, 0, 0), 1, 0, 0, 0, 1, 1, 0};
        tbl[8] = '{nop, 1, 0, 0, 0, 1, 1, 0};
        tbl[9] = '{nop, 1, 0, 0, 0, 0, 1, 0};

        #2;
        do_reset();

        for (int k = 0; k < 10; k++) begin
            step(tbl[k].ii, tbl[k].ordy, tbl[k].fl, tbl[k].rv, tbl[k].rd);
            chk($sformatf("tbl%0d_out_valid", k), s_ov, tbl[k].e_ov);
            chk($sformatf("tbl%0d_in_ready", k), s_irdy, tbl[k].e_irdy);
            if (tbl[k].e_ov) chk($sformatf("tbl%0d_out_dst_we", k), s_we, tbl[k].e_we);
        end
        chk("raw_stall_total", stall_cnt, PERF ? 3 : 0);
        chk("raw_cnt5", dut.cnt[5], 0);

        // Independent stream: four issues on consecutive cycles.
        step(mk(1, 64'h10, 1, 10, 1, 11, 1, 1), 1, 0, 0, 0);
        step(mk(1, 64'h11, 1, 12, 1, 13, 1, 2), 1, 0, 0, 0); chk("stream_iss0", s_ov, 1);
        step(mk(1, 64'h12, 1, 14, 1, 15, 1, 3), 1, 0, 0, 0); chk("stream_iss1", s_ov, 1);
        step(mk(1, 64'h13, 1, 16, 1, 17, 1, 4), 1, 0, 0, 0); chk("stream_iss2", s_ov, 1);
        step(nop, 1, 0, 0, 0);                               chk("stream_iss3", s_ov, 1);
        for (int r = 1; r <= 4; r++) step(nop, 1, 0, 1, r);
        for (int r = 1; r <= 4; r++) chk($sformatf("stream_cnt%0d", r), dut.cnt[r], 0);

        // Saturation at MAX_INFL writers to r7.
        for (int k = 0; k < 4; k++) step(mk(1, 64'h70 + k, 0, 0, 0, 0, 1, 7), 1, 0, 0, 0);
        chk("sat_cnt7", dut.cnt[7], 3);
        step(nop, 1, 0, 1, 7); chk("sat_stalled", s_ov, 0);
        step(nop, 1, 0, 0, 0); chk("sat_issue_after_retire", s_ov, 1);
        for (int k = 0; k < 3; k++) step(nop, 1, 0, 1, 7);
        chk("sat_cnt7_drained", dut.cnt[7], 0);

        // Simultaneous issue and retire of r9.
        step(mk(1, 64'h90, 0, 0, 0, 0, 1, 9), 1, 0, 0, 0);
        step(mk(1, 64'h91, 0, 0, 0, 0, 1, 9), 1, 0, 0, 0);
        step(nop, 1, 0, 1, 9); chk("incdec_issue", s_ov, 1);
        chk("incdec_cnt9", dut.cnt[9], 1);
        step(nop, 1, 0, 1, 9);

        // Flush kills the held instruction and ignores a same-cycle in_valid.
        step(mk(1, 64'hF0, 0, 0, 0, 0, 1, 11), 1, 0, 0, 0);
        step(mk(1, 64'hF1, 0, 0, 0, 0, 1, 12), 1, 1, 0, 0); chk("flush_no_issue", s_ov, 0);
        chk("flush_cnt11", dut.cnt[11], 0);
        step(nop, 1, 0, 0, 0); chk("flush_cleared", s_ov, 0);
        chk("flush_in_ready", s_irdy, 1);

        // Randomized traffic, with a mid-run reset.
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 1500; c++) begin
                ins_t r;
                bit rv;
                int rd;
                r = mk($urandom_range(0, 9) < 7, {$urandom, $urandom},
                       1'($urandom_range(0, 1)), $urandom_range(0, 7),
                       1'($urandom_range(0, 1)), $urandom_range(0, 7),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 7));
                rv = 0; rd = 0;
                if (pend.size() > 0 && $urandom_range(0, 9) < 4) begin
                    rv = 1; rd = pend[$urandom_range(0, pend.size() - 1)];
                end else if ($urandom_range(0, 19) == 0) begin
                    rv = 1; rd = 0;
                end
                step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rv, rd);
            end
            if (phase == 0) begin
                chk_all_cnt("mid");
                do_reset();
            end
        end
        step(nop, 1, 1, 0, 0);
        while (pend.size() > 0) step(nop, 1, 0, 1, pend[0]);
        chk_all_cnt("drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
